// File: rtl/csr_regfile_if.sv
// WB-stage CSR bus: the pipeline (master) drives reads, writes, exception
// entry and ertn; the CSR file (slave) answers with read data and redirect PCs.
interface csr_regfile_if;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_wmask;
    logic        ertn_flush;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_subecode;
    logic [31:0] wb_pc;
    logic [31:0] wb_badv;
    logic [31:0] csr_rd_value;
    logic [31:0] ex_entry;
    logic [31:0] era_pc;
    logic        has_int;

    modport master (
        output csr_num, csr_we, csr_wvalue, csr_wmask, ertn_flush,
               wb_ex, wb_ecode, wb_subecode, wb_pc, wb_badv,
        input  csr_rd_value, ex_entry, era_pc, has_int
    );

    modport slave (
        input  csr_num, csr_we, csr_wvalue, csr_wmask, ertn_flush,
               wb_ex, wb_ecode, wb_subecode, wb_pc, wb_badv,
        output csr_rd_value, ex_entry, era_pc, has_int
    );
endinterface

// File: rtl/csr_regfile.sv
// Architectural CSR file: combinational reads, masked writes, exception
// entry/return bookkeeping, interrupt sampling and the stable timer.
module csr_regfile #(
    parameter logic [31:0] TID_RESET  = 32'h0,
    parameter logic [31:0] CRMD_RESET = 32'h8
) (
    input  logic        clk,
    input  logic        resetn,
    csr_regfile_if.slave bus,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in
);
    localparam logic [13:0] ADDR_CRMD   = 14'h00;
    localparam logic [13:0] ADDR_PRMD   = 14'h01;
    localparam logic [13:0] ADDR_ECFG   = 14'h04;
    localparam logic [13:0] ADDR_ESTAT  = 14'h05;
    localparam logic [13:0] ADDR_ERA    = 14'h06;
    localparam logic [13:0] ADDR_BADV   = 14'h07;
    localparam logic [13:0] ADDR_EENTRY = 14'h0C;
    localparam logic [13:0] ADDR_SAVE0  = 14'h30;
    localparam logic [13:0] ADDR_TID    = 14'h40;
    localparam logic [13:0] ADDR_TCFG   = 14'h41;
    localparam logic [13:0] ADDR_TVAL   = 14'h42;
    localparam logic [13:0] ADDR_TICLR  = 14'h44;

    logic [31:0] crmd_reg, crmd_next;
    logic [31:0] prmd_reg, prmd_next;
    logic [31:0] ecfg_reg, ecfg_next;
    logic [31:0] estat_reg, estat_next;
    logic [31:0] era_reg, era_next;
    logic [31:0] badv_reg, badv_next;
    logic [31:0] eentry_reg, eentry_next;
    logic [31:0] tid_reg, tid_next;
    logic [31:0] tcfg_reg, tcfg_next;
    logic [31:0] tval_reg, tval_next;
    logic [3:0][31:0] save_bus;
    logic [31:0] rd_value;

    logic wr_en;
    logic tcfg_wr;
    logic ticlr_clr;
    logic timer_fire;

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] wval,
                                          input logic [31:0] wmask,
                                          input logic [31:0] writable);
        return (old_val & ~(wmask & writable)) | (wval & wmask & writable);
    endfunction

    // Exception and ertn both suppress any CSR write committing alongside them.
    always_comb begin
        wr_en      = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
        tcfg_wr    = wr_en & (bus.csr_num == ADDR_TCFG);
        ticlr_clr  = wr_en & (bus.csr_num == ADDR_TICLR) & bus.csr_wvalue[0] & bus.csr_wmask[0];
        timer_fire = ~tcfg_wr & tcfg_reg[0] & (tval_reg == 32'd1);
    end

    always_comb begin
        crmd_next   = crmd_reg;
        prmd_next   = prmd_reg;
        era_next    = era_reg;
        badv_next   = badv_reg;
        estat_next  = estat_reg;
        ecfg_next   = ecfg_reg;
        eentry_next = eentry_reg;
        tid_next    = tid_reg;
        tcfg_next   = tcfg_reg;

        if (bus.wb_ex) begin
            prmd_next[2:0] = crmd_reg[2:0];
            crmd_next[2:0] = 3'b000;
            era_next       = bus.wb_pc;
            estat_next[21:16] = bus.wb_ecode;
            estat_next[30:22] = bus.wb_subecode;
            if (bus.wb_ecode == 6'h08 || bus.wb_ecode == 6'h09)
                badv_next = bus.wb_badv;
        end else if (bus.ertn_flush) begin
            crmd_next[2:0] = prmd_reg[2:0];
        end else if (wr_en) begin
            case (bus.csr_num)
                ADDR_CRMD:   crmd_next   = merge(crmd_reg, bus.csr_wvalue, bus.csr_wmask, 32'h0000_0007);
                ADDR_PRMD:   prmd_next   = merge(prmd_reg, bus.csr_wvalue, bus.csr_wmask, 32'h0000_0007);
                ADDR_ECFG:   ecfg_next   = merge(ecfg_reg, bus.csr_wvalue, bus.csr_wmask, 32'h0000_1BFF);
                ADDR_ESTAT:  estat_next  = merge(estat_reg, bus.csr_wvalue, bus.csr_wmask, 32'h0000_0003);
                ADDR_ERA:    era_next    = merge(era_reg, bus.csr_wvalue, bus.csr_wmask, 32'hFFFF_FFFF);
                ADDR_BADV:   badv_next   = merge(badv_reg, bus.csr_wvalue, bus.csr_wmask, 32'hFFFF_FFFF);
                ADDR_EENTRY: eentry_next = merge(eentry_reg, bus.csr_wvalue, bus.csr_wmask, 32'hFFFF_FFC0);
                ADDR_TID:    tid_next    = merge(tid_reg, bus.csr_wvalue, bus.csr_wmask, 32'hFFFF_FFFF);
                ADDR_TCFG:   tcfg_next   = merge(tcfg_reg, bus.csr_wvalue, bus.csr_wmask, 32'hFFFF_FFFF);
                default: ;
            endcase
        end

        estat_next[9:2] = hw_int_in;
        estat_next[12]  = ipi_int_in;
        // A timer expiry beats a simultaneous TICLR so no tick is lost.
        if (timer_fire)
            estat_next[11] = 1'b1;
        else if (ticlr_clr)
            estat_next[11] = 1'b0;
    end

    always_comb begin
        tval_next = tval_reg;
        if (tcfg_wr)
            tval_next = {tcfg_next[31:2], 2'b00};
        else if (tcfg_reg[0] && tval_reg != 32'd0)
            tval_next = timer_fire ? (tcfg_reg[1] ? {tcfg_reg[31:2], 2'b00} : 32'd0)
                                   : tval_reg - 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_reg   <= CRMD_RESET;
            prmd_reg   <= '0;
            ecfg_reg   <= '0;
            estat_reg  <= '0;
            era_reg    <= '0;
            badv_reg   <= '0;
            eentry_reg <= '0;
            tid_reg    <= TID_RESET;
            tcfg_reg   <= '0;
            tval_reg   <= '0;
        end else begin
            crmd_reg   <= crmd_next;
            prmd_reg   <= prmd_next;
            ecfg_reg   <= ecfg_next;
            estat_reg  <= estat_next;
            era_reg    <= era_next;
            badv_reg   <= badv_next;
            eentry_reg <= eentry_next;
            tid_reg    <= tid_next;
            tcfg_reg   <= tcfg_next;
            tval_reg   <= tval_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_save
            logic [31:0] save_reg;
            logic        save_hit;
            assign save_hit = wr_en & (bus.csr_num == ADDR_SAVE0 + 14'(gi));
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    save_reg <= '0;
                else if (save_hit)
                    save_reg <= merge(save_reg, bus.csr_wvalue, bus.csr_wmask, 32'hFFFF_FFFF);
            end
            assign save_bus[gi] = save_reg;
        end
    endgenerate

    always_comb begin
        rd_value = '0;
        case (bus.csr_num)
            ADDR_CRMD:   rd_value = crmd_reg;
            ADDR_PRMD:   rd_value = prmd_reg;
            ADDR_ECFG:   rd_value = ecfg_reg;
            ADDR_ESTAT:  rd_value = estat_reg;
            ADDR_ERA:    rd_value = era_reg;
            ADDR_BADV:   rd_value = badv_reg;
            ADDR_EENTRY: rd_value = eentry_reg;
            14'h30, 14'h31, 14'h32, 14'h33: rd_value = save_bus[bus.csr_num[1:0]];
            ADDR_TID:    rd_value = tid_reg;
            ADDR_TCFG:   rd_value = tcfg_reg;
            ADDR_TVAL:   rd_value = tval_reg;
            default:     rd_value = '0;
        endcase
    end

    assign bus.csr_rd_value = rd_value;
    assign bus.ex_entry     = eentry_reg;
    assign bus.era_pc       = era_reg;
    assign bus.has_int      = crmd_reg[2] & |(estat_reg[12:0] & ecfg_reg[12:0]);
endmodule

// File: tb/tb_csr_regfile.sv
// Randomised and directed stimulus for csr_regfile, scored against an
// address-keyed reference table by an independent negedge monitor.
module tb_csr_regfile;
    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] hw_int_in;
    logic       ipi_int_in;

    csr_regfile_if bus();

    csr_regfile #(.TID_RESET(32'h0), .CRMD_RESET(32'h8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .hw_int_in  (hw_int_in),
        .ipi_int_in (ipi_int_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we, ex, ertn;
        logic [13:0] num;
        logic [31:0] wv, wm;
        logic [5:0]  ecode;
        logic [8:0]  sub;
        logic [31:0] pc, badv;
        logic [7:0]  hw;
        logic        ipi;
    } stim_t;

    typedef struct {
        string       name;
        logic [31:0] rd, rd_mask, ex_entry, era;
        logic        hi;
    } item_t;

    item_t       exp_q[$];
    bit          rd_valid = 1'b0;
    int          n_compared = 0;
    int          n_mismatch = 0;
    logic [31:0] m_csr [int];

    // ---------------- reference model ----------------
    function automatic logic [31:0] writable_of(input int a);
        case (a)
            'h00, 'h01: return 32'h0000_0007;
            'h04:       return 32'h0000_1BFF;
            'h05:       return 32'h0000_0003;
            'h0C:       return 32'hFFFF_FFC0;
            'h06, 'h07, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41: return 32'hFFFF_FFFF;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic void model_reset();
        int keys[16] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h07, 'h0C, 'h30,
                         'h31, 'h32, 'h33, 'h40, 'h41, 'h42, 'h42, 'h42};
        foreach (keys[i]) m_csr[keys[i]] = 32'h0;
        m_csr['h00] = 32'h8;
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] num);
        int a = int'(num);
        return m_csr.exists(a) ? m_csr[a] : 32'h0;
    endfunction

    function automatic logic model_has_int();
        logic [31:0] pend = m_csr['h05] & m_csr['h04];
        return m_csr['h00][2] & (pend[12:0] != 13'h0);
    endfunction

    function automatic void model_commit(input stim_t s);
        logic [31:0] crmd = m_csr['h00];
        logic [31:0] prmd = m_csr['h01];
        logic [31:0] tcfg = m_csr['h41];
        logic [31:0] tval = m_csr['h42];
        logic [31:0] est, msk;
        bit writing = s.we && !s.ex && !s.ertn;
        bit fire = 0, clr = 0;
        int a = int'(s.num);
        if (!(writing && a == 'h41) && tcfg[0] && tval != 0) begin
            if (tval == 1) begin
                fire = 1;
                tval = tcfg[1] ? {tcfg[31:2], 2'b00} : 32'h0;
            end else begin
                tval = tval - 1;
            end
        end
        m_csr['h42] = tval;
        if (s.ex) begin
            m_csr['h01] = {prmd[31:3], crmd[2:0]};
            m_csr['h00] = {crmd[31:3], 3'b000};
            m_csr['h06] = s.pc;
            est = m_csr['h05];
            est[21:16] = s.ecode;
            est[30:22] = s.sub;
            m_csr['h05] = est;
            if (s.ecode == 6'h08 || s.ecode == 6'h09) m_csr['h07] = s.badv;
        end else if (s.ertn) begin
            m_csr['h00] = {crmd[31:3], prmd[2:0]};
        end else if (s.we) begin
            if (a == 'h44) begin
                clr = s.wv[0] & s.wm[0];
            end else begin
                msk = writable_of(a) & s.wm;
                if (msk != 0 || writable_of(a) != 0) begin
                    m_csr[a] = (m_csr[a] & ~msk) | (s.wv & msk);
                    if (a == 'h41) m_csr['h42] = {m_csr['h41][31:2], 2'b00};
                end
            end
        end
        est = m_csr['h05];
        est[9:2] = s.hw;
        est[12]  = s.ipi;
        if (fire) est[11] = 1'b1;
        else if (clr) est[11] = 1'b0;
        m_csr['h05] = est;
    endfunction

    // ---------------- driver helpers ----------------
    function automatic stim_t idle(input logic [13:0] num);
        stim_t s;
        s = '{we: 1'b0, ex: 1'b0, ertn: 1'b0, num: num, wv: 32'h0, wm: 32'h0,
              ecode: 6'h0, sub: 9'h0, pc: 32'h0, badv: 32'h0, hw: 8'h0, ipi: 1'b0};
        return s;
    endfunction

    function automatic void push_exp(input string name, input logic [13:0] num, input bit use_const,
                                     input logic [31:0] exp_rd, input logic [31:0] mask, input int hi_exp);
        item_t e;
        e.name     = name;
        e.rd       = use_const ? exp_rd : model_read(num);
        e.rd_mask  = mask;
        e.ex_entry = m_csr['h0C];
        e.era      = m_csr['h06];
        e.hi       = (hi_exp < 0) ? model_has_int() : hi_exp[0];
        exp_q.push_back(e);
    endfunction

    task automatic run_cycle(input stim_t s, input string name, input bit use_const,
                             input logic [31:0] exp_rd, input logic [31:0] mask, input int hi_exp);
        bus.csr_num     = s.num;
        bus.csr_we      = s.we;
        bus.csr_wvalue  = s.wv;
        bus.csr_wmask   = s.wm;
        bus.ertn_flush  = s.ertn;
        bus.wb_ex       = s.ex;
        bus.wb_ecode    = s.ecode;
        bus.wb_subecode = s.sub;
        bus.wb_pc       = s.pc;
        bus.wb_badv     = s.badv;
        hw_int_in       = s.hw;
        ipi_int_in      = s.ipi;
        push_exp(name, s.num, use_const, exp_rd, mask, hi_exp);
        rd_valid = 1'b1;
        @(posedge clk);
        #1;
        model_commit(s);
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] wv, input logic [31:0] wm);
        stim_t s = idle(num);
        s.we = 1'b1;
        s.wv = wv;
        s.wm = wm;
        run_cycle(s, "write", 1'b0, 32'h0, 32'hFFFF_FFFF, -1);
    endtask

    task automatic rd(input string name, input logic [13:0] num, input logic [31:0] exp_rd,
                      input logic [31:0] mask, input int hi_exp);
        run_cycle(idle(num), name, 1'b1, exp_rd, mask, hi_exp);
    endtask

    function automatic stim_t rand_stim();
        stim_t s = idle(14'h0);
        case ($urandom_range(0, 16))
            0: s.num = 14'h00;  1: s.num = 14'h01;  2: s.num = 14'h04;  3: s.num = 14'h05;
            4: s.num = 14'h06;  5: s.num = 14'h07;  6: s.num = 14'h0C;  7: s.num = 14'h30;
            8: s.num = 14'h31;  9: s.num = 14'h32; 10: s.num = 14'h33; 11: s.num = 14'h40;
            12: s.num = 14'h41; 13: s.num = 14'h42; 14: s.num = 14'h44; 15: s.num = 14'h02;
            default: s.num = 14'h3FFF;
        endcase
        s.we   = ($urandom_range(0, 9) < 4);
        s.ex   = ($urandom_range(0, 39) == 0);
        s.ertn = ($urandom_range(0, 39) == 0);
        s.wv   = $urandom;
        s.wm   = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
        if (s.num == 14'h41) s.wv = (32'($urandom_range(0, 6)) << 2) | 32'($urandom_range(0, 3));
        s.ecode = $urandom_range(0, 1) ? 6'(8 + $urandom_range(0, 1)) : 6'($urandom_range(0, 63));
        s.sub   = 9'($urandom);
        s.pc    = $urandom;
        s.badv  = $urandom;
        s.hw    = 8'($urandom);
        s.ipi   = 1'($urandom);
        return s;
    endfunction

    // ---------------- monitor ----------------
    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_compared++;
        if (act !== exp_v) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endfunction

    always @(negedge clk) begin
        item_t e;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                e = exp_q.pop_front();
                cmp({e.name, "_rd"}, bus.csr_rd_value & e.rd_mask, e.rd & e.rd_mask);
                cmp({e.name, "_ex_entry"}, bus.ex_entry, e.ex_entry);
                cmp({e.name, "_era_pc"}, bus.era_pc, e.era);
                cmp({e.name, "_has_int"}, {31'h0, bus.has_int}, {31'h0, e.hi});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        resetn = 1'b0;
        model_reset();
        bus.csr_num = 14'h0; bus.csr_we = 1'b0; bus.csr_wvalue = 32'h0; bus.csr_wmask = 32'h0;
        bus.ertn_flush = 1'b0; bus.wb_ex = 1'b0; bus.wb_ecode = 6'h0; bus.wb_subecode = 9'h0;
        bus.wb_pc = 32'h0; bus.wb_badv = 32'h0; hw_int_in = 8'h0; ipi_int_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        rd("rst_crmd", 14'h00, 32'h8, 32'hFFFF_FFFF, 0);
        rd("rst_tval", 14'h42, 32'h0, 32'hFFFF_FFFF, 0);

        wr(14'h30, 32'hFFFF_FFFF, 32'h0000_FF00);
        rd("save0_masked", 14'h30, 32'h0000_FF00, 32'hFFFF_FFFF, -1);

        wr(14'h00, 32'h4, 32'hFFFF_FFFF);
        s = idle(14'h30);
        s.we = 1'b1; s.wv = 32'hDEAD_BEEF; s.wm = 32'hFFFF_FFFF;
        s.ex = 1'b1; s.ecode = 6'h09; s.pc = 32'h1C00_0100; s.badv = 32'h3;
        run_cycle(s, "ex_commit", 1'b0, 32'h0, 32'hFFFF_FFFF, -1);
        rd("ex_era", 14'h06, 32'h1C00_0100, 32'hFFFF_FFFF, -1);
        rd("ex_badv", 14'h07, 32'h3, 32'hFFFF_FFFF, -1);
        rd("ex_ecode", 14'h05, 32'h0009_0000, 32'h003F_0000, -1);
        rd("ex_pie", 14'h01, 32'h4, 32'h4, -1);
        rd("ex_ie_clear", 14'h00, 32'h0, 32'h4, -1);
        rd("ex_write_dropped", 14'h30, 32'h0000_FF00, 32'hFFFF_FFFF, -1);
        s = idle(14'h00);
        s.ertn = 1'b1;
        run_cycle(s, "ertn_commit", 1'b0, 32'h0, 32'hFFFF_FFFF, -1);
        rd("ertn_ie", 14'h00, 32'h4, 32'h4, -1);

        wr(14'h41, 32'h0000_000B, 32'hFFFF_FFFF);
        for (int i = 8; i >= 1; i--) rd("tval_periodic", 14'h42, 32'(i), 32'hFFFF_FFFF, -1);
        rd("tval_reload", 14'h42, 32'h8, 32'hFFFF_FFFF, -1);
        rd("timer_is11", 14'h05, 32'h800, 32'h800, -1);
        wr(14'h04, 32'h800, 32'hFFFF_FFFF);
        rd("has_int_timer", 14'h04, 32'h800, 32'hFFFF_FFFF, 1);
        wr(14'h44, 32'h1, 32'h1);
        rd("ticlr_clears", 14'h05, 32'h0, 32'h800, 0);
        wr(14'h41, 32'h0, 32'hFFFF_FFFF);

        wr(14'h41, 32'h0000_0005, 32'hFFFF_FFFF);
        for (int i = 4; i >= 1; i--) rd("tval_oneshot", 14'h42, 32'(i), 32'hFFFF_FFFF, -1);
        rd("tval_oneshot_zero", 14'h42, 32'h0, 32'hFFFF_FFFF, -1);
        rd("oneshot_is11", 14'h05, 32'h800, 32'h800, 1);
        for (int i = 0; i < 10; i++) rd("tval_hold_zero", 14'h42, 32'h0, 32'hFFFF_FFFF, -1);

        for (int i = 0; i < 1500; i++) run_cycle(rand_stim(), "random", 1'b0, 32'h0, 32'hFFFF_FFFF, -1);

        wr(14'h0C, 32'h1C00_8000, 32'hFFFF_FFFF);
        wr(14'h41, 32'h0000_0029, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) run_cycle(idle(14'h42), "pre_reset", 1'b0, 32'h0, 32'hFFFF_FFFF, -1);

        // Reset lands mid-cycle; the next negedge comes before any rising edge.
        #1 resetn = 1'b0;
        model_reset();
        bus.csr_num = 14'h42;
        push_exp("async_tval", 14'h42, 1'b1, 32'h0, 32'hFFFF_FFFF, 0);
        @(negedge clk); #1;
        bus.csr_num = 14'h05;
        push_exp("async_estat", 14'h05, 1'b1, 32'h0, 32'hFFFF_FFFF, 0);
        @(negedge clk); #1;
        bus.csr_num = 14'h41;
        push_exp("async_tcfg", 14'h41, 1'b1, 32'h0, 32'hFFFF_FFFF, 0);
        @(negedge clk); #1;
        rd_valid = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        rd("post_reset_crmd", 14'h00, 32'h8, 32'hFFFF_FFFF, 0);
        rd("post_reset_tval", 14'h42, 32'h0, 32'hFFFF_FFFF, 0);

        rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatch++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
